// File: rtl/neighbor_table_update_pkg.sv
// Shared definitions for the neighbour table updater: memory map, number format, FSM states.
// Latency: n/a (constants, types and one address helper only).
// Backpressure: n/a.
package neighbor_table_update_pkg;

    localparam int WORD_WIDTH = 16;

    // qValues and mybest are unsigned 11.5 fixed point.
    localparam int INT_BITS  = 11;
    localparam int FRAC_BITS = 5;
    localparam logic [WORD_WIDTH-1:0] FIX_ONE = 16'h0020;

    // Shared memory map (word addresses).
    localparam logic [WORD_WIDTH-1:0] MAP_ID_BASE  = 16'h00C8;
    localparam logic [WORD_WIDTH-1:0] MAP_Q_BASE   = 16'h01C8;
    localparam logic [WORD_WIDTH-1:0] MAP_HCM_BASE = 16'h0648;
    localparam logic [WORD_WIDTH-1:0] MAP_CNT_ADDR = 16'h068A;

    // Saturation value; a qValue never exceeds it.
    localparam logic [WORD_WIDTH-1:0] Q_SAT_INF = 16'hFFFE;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CNT,
        ST_ID,
        ST_Q,
        ST_CALC,
        ST_QWR,
        ST_NEW,
        ST_NEWQ,
        ST_NEWC,
        ST_DONE
    } state_t;

    // Tables are laid out with a two-word stride.
    function automatic logic [WORD_WIDTH-1:0] entry_addr(input logic [WORD_WIDTH-1:0] base,
                                                         input logic [7:0] idx);
        return base + {7'd0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/neighbor_table_update_q_update_calc.sv
// Q-learning step: target = min(mybest + hop, Q_INF); qnew = qold + (target - qold) >>> ALPHA_SHIFT.
// Latency: combinational.
// Backpressure: none.
// Ports: mybest/qold in (11.5 unsigned), target/qnew out (11.5 unsigned).
module q_update_calc
    import neighbor_table_update_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] HOP_COST    = FIX_ONE,
    parameter int                    ALPHA_SHIFT = 1,
    parameter logic [WORD_WIDTH-1:0] Q_INF       = Q_SAT_INF
) (
    input  logic [WORD_WIDTH-1:0] mybest,
    input  logic [WORD_WIDTH-1:0] qold,
    output logic [WORD_WIDTH-1:0] target,
    output logic [WORD_WIDTH-1:0] qnew
);

    logic        [WORD_WIDTH:0]   target_raw;
    logic signed [WORD_WIDTH+1:0] diff;
    logic signed [WORD_WIDTH+1:0] step;

    always_comb begin
        // 17-bit sum so the carry is visible to the saturation compare.
        target_raw = {1'b0, mybest} + {1'b0, HOP_COST};
        target     = (target_raw > {1'b0, Q_INF}) ? Q_INF : target_raw[WORD_WIDTH-1:0];
        diff       = $signed({2'b00, target}) - $signed({2'b00, qold});
        // Arithmetic shift rounds toward -inf, so qnew stays between qold and target.
        step       = diff >>> ALPHA_SHIFT;
        qnew       = 16'($signed({2'b00, qold}) + step);
    end

endmodule

// File: rtl/neighbor_table_update.sv
// Neighbour table updater: finds the packet sender in the shared-memory ID table, refreshes or appends its qValue.
// Latency: start to done = 5+i (hit at i), 4+cnt (miss, 4 when empty), 2+cnt (miss, table full).
// Backpressure: none; memory is always ready, start is ignored while busy.
// Ports: clock/nrst (sync, active-low); start, pkt_src, pkt_mybest request; data_in read data;
//        address/data_out/wr_en registered memory bus; done pulse with hit/table_full status.
module neighbor_table_update
    import neighbor_table_update_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] CNT_ADDR      = MAP_CNT_ADDR,
    parameter logic [WORD_WIDTH-1:0] ID_BASE       = MAP_ID_BASE,
    parameter logic [WORD_WIDTH-1:0] Q_BASE        = MAP_Q_BASE,
    parameter int                    MAX_NEIGHBORS = 16,
    parameter logic [WORD_WIDTH-1:0] HOP_COST      = FIX_ONE,
    parameter int                    ALPHA_SHIFT   = 1,
    parameter logic [WORD_WIDTH-1:0] Q_INF         = Q_SAT_INF
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] pkt_src,
    input  logic [WORD_WIDTH-1:0] pkt_mybest,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] address,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  wr_en,
    output logic                  done,
    output logic                  hit,
    output logic                  table_full
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_NEIGHBORS);

    state_t                state, state_nxt;
    logic [7:0]            idx, idx_nxt;
    logic [7:0]            cnt, cnt_nxt;
    logic [7:0]            idx_inc;
    logic [WORD_WIDTH-1:0] src_r, src_nxt;
    logic [WORD_WIDTH-1:0] mybest_r, mybest_nxt;
    logic [WORD_WIDTH-1:0] qold_r, qold_nxt;
    logic [WORD_WIDTH-1:0] qnew_r, qnew_nxt;
    logic [WORD_WIDTH-1:0] address_nxt, data_out_nxt;
    logic                  wr_en_nxt, done_nxt, hit_nxt, table_full_nxt;
    logic [WORD_WIDTH-1:0] target, qnew;

    q_update_calc #(
        .HOP_COST    (HOP_COST),
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .Q_INF       (Q_INF)
    ) u_calc (
        .mybest (mybest_r),
        .qold   (qold_r),
        .target (target),
        .qnew   (qnew)
    );

    assign idx_inc = idx + 8'd1;

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            idx        <= 8'd0;
            cnt        <= 8'd0;
            src_r      <= '0;
            mybest_r   <= '0;
            qold_r     <= '0;
            qnew_r     <= '0;
            address    <= CNT_ADDR;
            data_out   <= '0;
            wr_en      <= 1'b0;
            done       <= 1'b0;
            hit        <= 1'b0;
            table_full <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            src_r      <= src_nxt;
            mybest_r   <= mybest_nxt;
            qold_r     <= qold_nxt;
            qnew_r     <= qnew_nxt;
            address    <= address_nxt;
            data_out   <= data_out_nxt;
            wr_en      <= wr_en_nxt;
            done       <= done_nxt;
            hit        <= hit_nxt;
            table_full <= table_full_nxt;
        end
    end

    // Outputs are registered: done is raised on the edge that enters DONE,
    // so it is high exactly during the DONE cycle.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        cnt_nxt        = cnt;
        src_nxt        = src_r;
        mybest_nxt     = mybest_r;
        qold_nxt       = qold_r;
        qnew_nxt       = qnew_r;
        address_nxt    = address;
        data_out_nxt   = data_out;
        wr_en_nxt      = 1'b0;
        done_nxt       = 1'b0;
        hit_nxt        = hit;
        table_full_nxt = table_full;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    src_nxt        = pkt_src;
                    mybest_nxt     = pkt_mybest;
                    hit_nxt        = 1'b0;
                    table_full_nxt = 1'b0;
                    address_nxt    = CNT_ADDR;
                    state_nxt      = ST_CNT;
                end
            end

            ST_CNT: begin
                // A corrupt count larger than the capacity is treated as a full table.
                if (data_in > 16'(MAX_NEIGHBORS)) begin
                    cnt_nxt = MAX_CNT;
                end else begin
                    cnt_nxt = data_in[7:0];
                end
                idx_nxt = 8'd0;
                if (cnt_nxt == 8'd0) begin
                    state_nxt = ST_NEW;
                end else begin
                    address_nxt = ID_BASE;
                    state_nxt   = ST_ID;
                end
            end

            ST_ID: begin
                // Linear scan; the lowest matching index wins.
                if (data_in == src_r) begin
                    address_nxt = entry_addr(Q_BASE, idx);
                    state_nxt   = ST_Q;
                end else begin
                    idx_nxt = idx_inc;
                    if (idx_inc == cnt) begin
                        state_nxt = ST_NEW;
                    end else begin
                        address_nxt = entry_addr(ID_BASE, idx_inc);
                    end
                end
            end

            ST_Q: begin
                qold_nxt  = data_in;
                state_nxt = ST_CALC;
            end

            ST_CALC: begin
                // Register the update so the subtract/shift path does not
                // chain directly from memory read data onto the write bus.
                qnew_nxt  = qnew;
                state_nxt = ST_QWR;
            end

            ST_QWR: begin
                address_nxt  = entry_addr(Q_BASE, idx);
                data_out_nxt = qnew_r;
                wr_en_nxt    = 1'b1;
                hit_nxt      = 1'b1;
                done_nxt     = 1'b1;
                state_nxt    = ST_DONE;
            end

            ST_NEW: begin
                if (cnt >= MAX_CNT) begin
                    table_full_nxt = 1'b1;
                    done_nxt       = 1'b1;
                    state_nxt      = ST_DONE;
                end else begin
                    address_nxt  = entry_addr(ID_BASE, cnt);
                    data_out_nxt = src_r;
                    wr_en_nxt    = 1'b1;
                    state_nxt    = ST_NEWQ;
                end
            end

            ST_NEWQ: begin
                // A new neighbour starts directly at its target, no averaging.
                address_nxt  = entry_addr(Q_BASE, cnt);
                data_out_nxt = target;
                wr_en_nxt    = 1'b1;
                state_nxt    = ST_NEWC;
            end

            ST_NEWC: begin
                // Count is written last so the min-search never sees a half-built entry.
                address_nxt  = CNT_ADDR;
                data_out_nxt = {8'd0, cnt + 8'd1};
                wr_en_nxt    = 1'b1;
                done_nxt     = 1'b1;
                state_nxt    = ST_DONE;
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/neighbor_table_update.md
Name: neighbor_table_update

Overview:
- Upstream feeder of the my-best-Q stage.
- On each received routing packet, looks up the sender in the neighbour ID table in shared memory.
  - On a hit, updates that neighbour's qValue in place.
  - On a miss, appends a new neighbour with its ID, an initial qValue and an incremented neighborCount.
- Keeps the neighborCount (0x68A) and qValue (0x1C8 + 2*i) regions consistent for the downstream min-search.

Parameters:
- CNT_ADDR, 16'h068A, neighborCount word address.
- ID_BASE, 16'h00C8, neighbour ID table base; entry i at ID_BASE + 2*i.
- Q_BASE, 16'h01C8, qValue table base; entry i at Q_BASE + 2*i.
- MAX_NEIGHBORS, 16, table capacity (≤128).
- HOP_COST, 16'h0020, per-hop cost, unsigned 11.5 fixed point (1.0).
- ALPHA_SHIFT, 1, learning rate = 2^-ALPHA_SHIFT.
- Q_INF, 16'hFFFE, saturation/"infinite" Q value.

Ports:
- clock  in  1  clock, rising edge.
- nrst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- pkt_src  in  16  sender node ID.
- pkt_mybest  in  16  sender's advertised mybest, 11.5 fixed point.
- data_in  in  16  memory read data; mem[address] valid the cycle after address is registered.
- address  out  16  memory word address (registered).
- data_out  out  16  memory write data (registered).
- wr_en  out  1  memory write strobe, one cycle per write.
- done  out  1  one-cycle completion pulse.
- hit  out  1  valid with done: sender was already in table.
- table_full  out  1  valid with done: miss with table full; no writes issued.

Behaviour:
- Reset (nrst=0 at edge) values:
  - address=CNT_ADDR; data_out=0; wr_en=0; done=0; hit=0; table_full=0.
  - state=IDLE; index i=0.
- Reset mid-operation aborts immediately; any write already issued stays in memory. No partial-append recovery is provided.
- IDLE:
  - On start: latch pkt_src and pkt_mybest; clear hit and table_full; address=CNT_ADDR; go CNT.
  - start while not IDLE is ignored.
- CNT:
  - Capture cnt = min(data_in, MAX_NEIGHBORS); i=0.
  - If cnt==0, go NEW.
  - Otherwise address=ID_BASE, go ID.
- ID (one entry per cycle):
  - If data_in==src: address=Q_BASE+2*i, go Q.
  - Otherwise i=i+1.
    - If i==cnt, go NEW.
    - Otherwise address=ID_BASE+2*i and stay in ID.
- Q: capture qold=data_in; go CALC.
- CALC:
  - target = min(pkt_mybest + HOP_COST, Q_INF), computed in 17 bits.
  - diff = target - qold, 18-bit signed.
  - qnew = qold + (diff >>> ALPHA_SHIFT), arithmetic shift. qnew always lies between qold and target, so no further clamp is needed.
  - Issue write: address=Q_BASE+2*i, data_out=qnew, wr_en=1. Set hit=1; go DONE.
- NEW:
  - If cnt ≥ MAX_NEIGHBORS: table_full=1; go DONE with no writes.
  - Otherwise write ID_BASE+2*cnt ← src; go NEWQ.
- NEWQ: write Q_BASE+2*cnt ← target (initial Q, no averaging); go NEWC.
- NEWC: write CNT_ADDR ← cnt+1; go DONE.
- DONE:
  - wr_en=0; done=1 for exactly one cycle; go IDLE.
  - hit and table_full hold until the next start.
- Latency, counted from the start-sampling edge to done high:
  - Hit at index i: 5+i cycles.
  - Miss with space: 4+cnt cycles, or 4 when cnt==0.
  - Miss with table full: 2+cnt cycles.
- Duplicate IDs in the table: the first match (lowest i) wins.
- All arithmetic is unsigned 11.5 except diff. Q_INF is never exceeded.

Decomposition:
- Shared package/include holds:
  - Memory map constants: CNT_ADDR, ID_BASE, Q_BASE, HCM base 0x648.
  - WORD_WIDTH=16 and fixed-point format constants (11.5).
  - Q_INF.
  - State encoding.
- One natural sub-module, q_update_calc: purely combinational, computes target and qnew from qold, pkt_mybest, HOP_COST and ALPHA_SHIFT, so it can be unit-tested on its own.

Test Plan:
1. Empty table (mem[0x68A]=0), start src=7, mybest=0x0040 → writes 0x0C8←7, 0x1C8←0x0060, 0x68A←1; done at cycle 4; hit=0, table_full=0.
2. Hit at i=0 (ID[0]=7, Q[0]=0x0100, count=1), mybest=0x0040 → single write 0x1C8←0x00B0; done at cycle 5; hit=1.
3. Hit at i=2 of 3, mybest=0xFFF0, qold=0xFFFE → target saturates to 0xFFFE; write Q_BASE+4←0xFFFE; done at cycle 7.
4. Table full (count=16), unknown src → no wr_en at all; table_full=1; done at cycle 18.
5. Memory count=40 → clamped to 16; behaves as scenario 4. Second start pulse mid-search is ignored, with exactly one done.
6. Reset asserted in ID state → next cycle all outputs at reset values; a subsequent start runs normally.
